// File: rtl/param_counter.sv
// param_counter: two-phase (master/slave) up/down counter with a parameterised
// step and either modular wrap or clamping at the range limits.
// The rising edge of cl computes the next value into a stage register.
// The falling edge publishes the stage value on q and the stage flag on wrap.
// Reset takes effect on q and wrap at the rising edge itself.
module param_counter #(
    parameter int              WIDTH    = 16,
    parameter longint unsigned STEP     = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             cl,
    input  logic             rst,
    input  logic             st,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             dn,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    // Step widened by one bit so that the carry out of the counter width and
    // the "value below step" test can both be evaluated without truncation.
    localparam logic [WIDTH:0]   StepExt = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MaxVal  = '1;
    localparam logic [WIDTH-1:0] MinVal  = '0;

    // Master stage, written on the rising edge.
    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;
    logic             flag_q;
    logic             flag_d;

    // Set on a rising edge that sampled rst, so the outputs read zero straight
    // away instead of waiting for the falling edge to copy the cleared stage.
    logic             rstHold_q;

    // Slave stage, written on the falling edge.
    logic [WIDTH-1:0] pubVal_q;
    logic             pubWrap_q;

    // Arithmetic candidates for the two count directions.
    logic [WIDTH:0]   sumExt;
    logic [WIDTH-1:0] diffVal;
    logic             overflow;
    logic             underflow;

    assign sumExt    = {1'b0, stage_q} + StepExt;
    assign overflow  = sumExt[WIDTH];
    assign diffVal   = stage_q - StepExt[WIDTH-1:0];
    assign underflow = ({1'b0, stage_q} < StepExt);

    // Next stage value and event flag: load beats count, count beats hold.
    always_comb begin
        stage_d = stage_q;
        flag_d  = 1'b0;
        if (st) begin
            stage_d = d;
            flag_d  = 1'b0;
        end else if (en) begin
            if (!dn) begin
                if (overflow) begin
                    flag_d  = 1'b1;
                    stage_d = SATURATE ? MaxVal : sumExt[WIDTH-1:0];
                end else begin
                    stage_d = sumExt[WIDTH-1:0];
                end
            end else begin
                if (underflow) begin
                    flag_d  = 1'b1;
                    stage_d = SATURATE ? MinVal : diffVal;
                end else begin
                    stage_d = diffVal;
                end
            end
        end
    end

    // Rising edge: capture the next value, or clear everything on reset.
    always_ff @(posedge cl) begin
        if (rst) begin
            stage_q   <= '0;
            flag_q    <= 1'b0;
            rstHold_q <= 1'b1;
        end else begin
            stage_q   <= stage_d;
            flag_q    <= flag_d;
            rstHold_q <= 1'b0;
        end
    end

    // Falling edge: publish the stage so q and wrap only move here.
    always_ff @(negedge cl) begin
        pubVal_q  <= stage_q;
        pubWrap_q <= flag_q;
    end

    // While a reset is held the outputs are forced low; once it releases the
    // slave already holds the cleared stage, so the switch-over is seamless.
    assign q    = rstHold_q ? '0   : pubVal_q;
    assign wrap = rstHold_q ? 1'b0 : pubWrap_q;

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of d and q; legal range 1..32.
REQ-002 SHALL have parameter STEP, default 1: increment/decrement magnitude; legal range 1..2^WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = modular wrap, 1 = clamp at 0 and 2^WIDTH-1.
REQ-004 SHALL have port: cl  input  1  single clock; positive edge samples inputs, negative edge publishes outputs.
REQ-005 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of cl.
REQ-006 SHALL have port: st  input  1  store: load d into the counter.
REQ-007 SHALL have port: d  input  WIDTH  load value.
REQ-008 SHALL have port: en  input  1  count enable.
REQ-009 SHALL have port: dn  input  1  direction: 0 = up, 1 = down.
REQ-010 SHALL have port: q  output  WIDTH  published counter value.
REQ-011 SHALL have port: wrap  output  1  overflow/underflow (SATURATE=0) or clamp (SATURATE=1) event flag.

Function
REQ-012 SHALL be two-phase (master/slave): rising edge of cl computes the next value from the current q into an internal stage register; falling edge copies stage to q and the stage flag to wrap.
REQ-013 SHALL leave q and wrap stable between falling edges; a change sampled at rising edge N appears on q at the falling edge of the same cycle.
REQ-014 SHALL apply priority rst > st > en at each rising edge.
REQ-015 SHALL, when st=1 and rst=0, stage d and clear the stage flag, regardless of en and dn.
REQ-016 SHALL, when en=1, st=0, dn=0, stage q+STEP computed at WIDTH+1 bits; a carry out of bit WIDTH-1 is an overflow.
REQ-017 SHALL, when en=1, st=0, dn=1, stage q-STEP; q < STEP is an underflow.
REQ-018 SHALL, when SATURATE=0, stage the result modulo 2^WIDTH and set the stage flag to 1 only on overflow or underflow.
REQ-019 SHALL, when SATURATE=1, clamp an overflow to 2^WIDTH-1 and an underflow to 0, and set the stage flag to 1 on every enabled step where clamping occurs, including repeated steps while q is already held at the limit.
REQ-020 SHALL, when en=0, st=0, rst=0, hold the stage value and clear the stage flag.
REQ-021 SHALL assert wrap for exactly one cycle per event (falling edge to falling edge) unless the event repeats on consecutive cycles.
REQ-022 SHALL ignore dn whenever en=0 or st=1.

Reset
REQ-023 SHALL, when rst=1 at a rising edge of cl, clear stage, stage flag, q and wrap to 0 at that rising edge, without waiting for the falling edge.
REQ-024 SHALL hold q=0 and wrap=0 on every cycle rst remains high, overriding st and en.
REQ-025 SHALL, on the first rising edge with rst=0, resume normal operation from q=0.
REQ-026 SHALL have q and wrap undefined before the first reset; the bench SHALL reset before checking.

Verification
(WIDTH=4, STEP=1 unless stated.)
REQ-027 SHALL be checked for reset mid-count: q=9 counting up, rst=1 for 1 cycle -> q=0 and wrap=0 at that rising edge; next cycle with en=1 -> q=1 at the falling edge.
REQ-028 SHALL be checked for load versus count priority: st=1, d=7, en=1, dn=1 -> q=7, wrap=0; then en=1, dn=0 for 3 cycles -> q=8, 9, 10.
REQ-029 SHALL be checked for modular wrap (SATURATE=0): load 14, count up -> q=15 with wrap=0, then q=0 with wrap=1 for one cycle, then q=1 with wrap=0; load 0, count down -> q=15 with wrap=1.
REQ-030 SHALL be checked for saturation (SATURATE=1): load 14, count up 3 cycles -> q=15, 15, 15 with wrap=0, 1, 1; then dn=1 -> q=14 with wrap=0.
REQ-031 SHALL be checked for STEP=3, WIDTH=4, SATURATE=0: load 13, count up -> q=0 with wrap=1; then count down -> q=13 with wrap=1.
REQ-032 SHALL be checked for phase timing: load 5 with st held high, then change d to 6 while cl is high -> q updates only at the falling edge, keeps the value sampled at the rising edge (5), and shows no glitch while cl is high.
